// File: rtl/raster_addr_gen_if.sv
// Handshake and configuration bundle for raster_addr_gen.
// The frame-buffer side drives through master; the generator uses slave.
interface raster_addr_gen_if #(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 11,
  parameter int ADDR_W = ROW_W + COL_W
);
  logic              start;
  logic [COL_W-1:0]  col_max;
  logic [ROW_W-1:0]  row_max;
  logic              plane_en;
  logic [1:0]        plane_sel;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] address;
  logic [ROW_W-1:0]  row;
  logic [COL_W-1:0]  col;
  logic [1:0]        bayer_ph;
  logic              eol;
  logic              last;
  logic              busy;
  logic              frame_done;

  modport master (
    output start, col_max, row_max, plane_en, plane_sel, out_ready,
    input  out_valid, address, row, col, bayer_ph, eol, last, busy, frame_done
  );

  modport slave (
    input  start, col_max, row_max, plane_en, plane_sel, out_ready,
    output out_valid, address, row, col, bayer_ph, eol, last, busy, frame_done
  );
endinterface

// File: rtl/raster_addr_gen.sv
// Raster / Bayer-plane address walker: emits row*col_max+col per handshake,
// built from a running row base so no multiplier is needed.
//   state  | meaning
//   S_IDLE | waiting for start, config inputs sampled on start
//   S_RUN  | beats being offered on out_valid
//   S_DONE | frame_done pulse, start ignored
module raster_addr_gen #(
  parameter int ROW_W  = 11,
  parameter int COL_W  = 11,
  parameter int ADDR_W = ROW_W + COL_W
) (
  input  logic clk,
  input  logic rst,
  raster_addr_gen_if.slave bus
);
  localparam int CW1 = COL_W + 1;
  localparam int RW1 = ROW_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [COL_W-1:0]  col_max_q, col_max_d;
  logic [ROW_W-1:0]  row_max_q, row_max_d;
  logic              plane_q, plane_d;
  logic              c0_q, c0_d;
  logic [ADDR_W-1:0] rstep_q, rstep_d;
  logic [ADDR_W-1:0] rbase_q, rbase_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic              eol_q, eol_d;
  logic              last_q, last_d;

  logic              r0_in, c0_in, empty_in;
  logic [1:0]        step_cur, step_nx;
  logic [CW1-1:0]    col_nx_w;
  logic [RW1-1:0]    row_nx_w;

  always_comb begin
    state_d   = state_q;
    col_max_d = col_max_q;
    row_max_d = row_max_q;
    plane_d   = plane_q;
    c0_d      = c0_q;
    rstep_d   = rstep_q;
    rbase_d   = rbase_q;
    row_d     = row_q;
    col_d     = col_q;

    r0_in    = bus.plane_en & bus.plane_sel[1];
    c0_in    = bus.plane_en & bus.plane_sel[0];
    empty_in = (bus.col_max <= COL_W'(c0_in)) || (bus.row_max <= ROW_W'(r0_in));
    step_cur = plane_q ? 2'd2 : 2'd1;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          col_max_d = bus.col_max;
          row_max_d = bus.row_max;
          plane_d   = bus.plane_en;
          c0_d      = c0_in;
          // Row stride is col_max or 2*col_max; the starting row is 0 or 1.
          rstep_d   = bus.plane_en ? (ADDR_W'(bus.col_max) << 1) : ADDR_W'(bus.col_max);
          rbase_d   = r0_in ? ADDR_W'(bus.col_max) : '0;
          row_d     = ROW_W'(r0_in);
          col_d     = COL_W'(c0_in);
          state_d   = empty_in ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (bus.out_ready) begin
          if (last_q) begin
            state_d = S_DONE;
          end else if (eol_q) begin
            col_d   = COL_W'(c0_q);
            row_d   = row_q + ROW_W'(step_cur);
            rbase_d = rbase_q + rstep_q;
          end else begin
            col_d = col_q + COL_W'(step_cur);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Flags for the beat about to be presented, one bit wider to absorb col+2 overflow.
    step_nx  = plane_d ? 2'd2 : 2'd1;
    col_nx_w = {1'b0, col_d} + CW1'(step_nx);
    row_nx_w = {1'b0, row_d} + RW1'(step_nx);
    addr_d   = rbase_d + ADDR_W'(col_d);
    eol_d    = (state_d == S_RUN) && (col_nx_w >= {1'b0, col_max_d});
    last_d   = eol_d && (row_nx_w >= {1'b0, row_max_d});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_max_q <= '0;
      row_max_q <= '0;
      plane_q   <= 1'b0;
      c0_q      <= 1'b0;
      rstep_q   <= '0;
      rbase_q   <= '0;
      addr_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      eol_q     <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_max_q <= col_max_d;
      row_max_q <= row_max_d;
      plane_q   <= plane_d;
      c0_q      <= c0_d;
      rstep_q   <= rstep_d;
      rbase_q   <= rbase_d;
      addr_q    <= addr_d;
      row_q     <= row_d;
      col_q     <= col_d;
      eol_q     <= eol_d;
      last_q    <= last_d;
    end
  end

  assign bus.out_valid  = (state_q == S_RUN);
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.frame_done = (state_q == S_DONE);
  assign bus.address    = addr_q;
  assign bus.row        = row_q;
  assign bus.col        = col_q;
  assign bus.bayer_ph   = {row_q[0], col_q[0]};
  assign bus.eol        = eol_q;
  assign bus.last       = last_q;
endmodule
